seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: double-buffered display word, blanking gap
// between digits, leading-zero suppression. Define SEG_PWM_EN to add a 4-bit brightness input.
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 12000,
  parameter int BLANK_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]     load_dp,
  input  logic                  lz_suppress,
`ifdef SEG_PWM_EN
  input  logic [3:0]            brightness,
`endif
  output logic [3:0]            seg_data,
  output logic                  seg_dp,
  output logic                  seg_blank,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] act_data;
  logic [DIGITS-1:0]   act_dp;
  logic [4*DIGITS-1:0] pend_data;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_full;

  logic                accept;
  logic [DIGITS-1:0]   lz_mask;
  logic                zero_run;
  logic                pwm_on;
  logic                lit;
  logic [3:0]          cur_nib;

  assign load_ready  = !pend_full;
  assign accept      = load_valid && load_ready;
  assign frame_start = (state == ST_BLANK) && (cnt == '0) && (idx == '0);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_BLANK;
      cnt       <= '0;
      idx       <= '0;
      act_data  <= '0;
      act_dp    <= '0;
      pend_full <= 1'b0;
    end else begin
      if (cnt == CW'(SCAN_DIV - 1)) begin
        cnt   <= '0;
        state <= ST_BLANK;
        idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(BLANK_CYC - 1))
          state <= ST_DRIVE;
      end

      // Active word only swaps at a frame boundary so a frame never mixes two words.
      if (frame_start && pend_full) begin
        act_data  <= pend_data;
        act_dp    <= pend_dp;
        pend_full <= 1'b0;
      end else if (accept) begin
        pend_full <= 1'b1;
      end
    end
  end

  // NOTE: the pending payload has no reset; pend_full alone decides whether it is meaningful.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_data <= load_data;
      pend_dp   <= load_dp;
    end
  end

  // NOTE: combinational logic uses blocking assignments with defaults first, so no latch is inferred.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run && (act_data[4*i +: 4] == 4'h0) && !act_dp[i];
      lz_mask[i] = zero_run;
    end
  end

`ifdef SEG_PWM_EN
  localparam int PWM_D = (SCAN_DIV - BLANK_CYC) / 16;
  assign pwm_on = (int'(cnt) - BLANK_CYC) < ((int'(brightness) + 1) * PWM_D);
`else
  assign pwm_on = 1'b1;
`endif

  assign cur_nib = act_data[{idx, 2'b00} +: 4];
  assign lit     = (state == ST_DRIVE) && !(lz_suppress && lz_mask[idx]) && pwm_on;

  always_comb begin
    seg_data  = 4'h0;
    seg_dp    = 1'b0;
    seg_blank = 1'b1;
    dig_sel   = '1;
    if (lit) begin
      seg_data     = cur_nib;
      seg_dp       = act_dp[idx];
      seg_blank    = 1'b0;
      dig_sel[idx] = 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2 (SCAN_DIV=34 when SEG_PWM_EN).
module tb_seg_scan_ctrl;

`ifdef SEG_PWM_EN
  localparam int SD = 34;
`else
  localparam int SD = 8;
`endif
  localparam int BC = 2;
  localparam int ND = 4;
  localparam int FR = ND * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic        lz_suppress;
  logic [3:0]  seg_data;
  logic        seg_dp;
  logic        seg_blank;
  logic [3:0]  dig_sel;
  logic        frame_start;
`ifdef SEG_PWM_EN
  logic [3:0]  brightness;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_dp     (load_dp),
    .lz_suppress (lz_suppress),
`ifdef SEG_PWM_EN
    .brightness  (brightness),
`endif
    .seg_data    (seg_data),
    .seg_dp      (seg_dp),
    .seg_blank   (seg_blank),
    .dig_sel     (dig_sel),
    .frame_start (frame_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Packed observation: {frame_start, seg_blank, seg_dp, seg_data, dig_sel}
  function automatic logic [10:0] obs();
    return {frame_start, seg_blank, seg_dp, seg_data, dig_sel};
  endfunction

  function automatic logic [10:0] expect_at(input int c, input logic [15:0] w,
                                            input logic [3:0] d, input logic lz);
    int slot, pos;
    logic sup, lit;
    logic [3:0] nib, sel;
    slot = (c % FR) / SD;
    pos  = c % SD;
    sup  = lz && (slot > 0) && ((w >> (4 * slot)) == 16'h0) && ((d >> slot) == 4'h0);
    lit  = (pos >= BC) && !sup;
    nib  = w[4*slot +: 4];
    sel  = 4'hF;
    if (lit) sel[slot] = 1'b0;
    return {(pos == 0 && slot == 0), !lit, lit ? d[slot] : 1'b0, lit ? nib : 4'h0, sel};
  endfunction

  // Checks every cycle until the next frame start; optionally offers a word at frame offset 1.
  task automatic run_frame(input logic [15:0] w, input logic [3:0] d, input logic lz,
                           input logic ld, input logic [15:0] lw, input logic [3:0] ldp);
    lz_suppress = lz;
    do begin
      check($sformatf("frame_%04h", w), 32'(obs()), 32'(expect_at(cyc, w, d, lz)));
      if (ld && (cyc % FR == 1)) begin
        check("ready_hi", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_data  = lw;
        load_dp    = ldp;
      end
      tick();
      load_valid = 1'b0;
      if (ld && (cyc % FR == 2)) check("ready_lo", 32'(load_ready), 32'd0);
    end while (cyc % FR != 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_outs"}, 32'({seg_blank, seg_dp, seg_data, dig_sel}), 32'({1'b1, 1'b0, 4'h0, 4'hF}));
    check({tag, "_ready"}, 32'(load_ready), 32'd1);
    check({tag, "_fs"}, 32'(frame_start), 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    load_valid  = 1'b0;
    load_data   = 16'h0;
    load_dp     = 4'h0;
    lz_suppress = 1'b0;
`ifdef SEG_PWM_EN
    brightness  = 4'd15;
`endif
    repeat (3) tick();
    rst = 1'b0;
    cyc = 0;

`ifdef SEG_PWM_EN
    check_reset_vals("rst");
    foreach (brightness_list[k]) begin
      brightness = brightness_list[k];
      while (cyc % SD != 0) tick();
      for (int p = 0; p < SD; p++) begin
        logic on;
        logic [3:0] sel;
        on  = (p >= BC) && ((p - BC) < (int'(brightness_list[k]) + 1) * 2);
        sel = 4'hF;
        if (on) sel[(cyc % FR) / SD] = 1'b0;
        check($sformatf("pwm_b%0d", brightness_list[k]), 32'({seg_blank, dig_sel}), 32'({!on, sel}));
        tick();
      end
    end
`else
    // Reset state, then load 1234 at cycle 1 and offer ABCD while pending is full.
    check_reset_vals("rst");
    tick();
    check("fs_c1", 32'(frame_start), 32'd0);
    load_valid = 1'b1; load_data = 16'h1234; load_dp = 4'b0000;
    tick();
    check("ready_c2", 32'(load_ready), 32'd0);
    load_data = 16'hABCD;
    tick();
    check("ready_c3", 32'(load_ready), 32'd0);
    tick();
    load_valid = 1'b0;
    check("ready_c4", 32'(load_ready), 32'd0);
    run_frame(16'h0000, 4'h0, 1'b0, 1'b0, 16'h0, 4'h0);
    check("fs_c32", 32'(frame_start), 32'd1);
    run_frame(16'h1234, 4'h0, 1'b0, 1'b1, 16'hABCD, 4'h0);
    run_frame(16'hABCD, 4'h0, 1'b0, 1'b1, 16'h0050, 4'h0);

    // Leading-zero suppression cases.
    run_frame(16'h0050, 4'h0, 1'b1, 1'b1, 16'h0000, 4'h0);
    run_frame(16'h0000, 4'h0, 1'b1, 1'b1, 16'h0050, 4'b0100);
    run_frame(16'h0050, 4'b0100, 1'b1, 1'b1, 16'h1234, 4'h0);
    run_frame(16'h1234, 4'h0, 1'b0, 1'b0, 16'h0, 4'h0);

    // Reset in the digit-2 DRIVE window.
    repeat (2 * SD + BC + 1) tick();
    check("pre_rst", 32'({seg_blank, seg_data, dig_sel}), 32'({1'b0, 4'h2, 4'b1011}));
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst = 1'b0;
    cyc = 0;
    run_frame(16'h0000, 4'h0, 1'b0, 1'b0, 16'h0, 4'h0);
    check("post_rst_ready", 32'(load_ready), 32'd1);
    run_frame(16'h0000, 4'h0, 1'b0, 1'b0, 16'h0, 4'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

`ifdef SEG_PWM_EN
  logic [3:0] brightness_list [3] = '{4'd7, 4'd15, 4'd0};
`endif

endmodule
